// File: rtl/fpnew_sdotp_result_fifo.sv
// In-order result buffer between the SDOTP lane wrapper and writeback, with sticky fflags.
// Optional zero-latency empty-FIFO bypass: define FPNEW_SDOTP_FIFO_BYPASS_EN.
module fpnew_sdotp_result_fifo #(
   parameter int unsigned LaneWidth = 64,
   parameter int unsigned Depth     = 2,
   parameter type         TagType   = logic,
   parameter type         AuxType   = logic,
   localparam int unsigned CntWidth = $clog2(Depth + 1),
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [LaneWidth-1:0] in_result_i,
   input  logic [4:0]           in_status_i,
   input  logic                 in_ext_bit_i,
   input  TagType               in_tag_i,
   input  AuxType               in_aux_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [LaneWidth-1:0] out_result_o,
   output logic [4:0]           out_status_o,
   output logic                 out_ext_bit_o,
   output TagType               out_tag_o,
   output AuxType               out_aux_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [4:0]           fflags_o,
   input  logic                 fflags_clr_i,
   output logic [CntWidth-1:0]  usage_o,
   output logic                 busy_o
);

   typedef struct packed {
      logic [LaneWidth-1:0] result;
      logic [4:0]           status;
      logic                 ext_bit;
      TagType               tag;
      AuxType               aux;
   } entry_t;

   entry_t                mem [Depth];
   entry_t                in_entry;
   entry_t                head;
   logic [PtrWidth-1:0]   rd_ptr, wr_ptr;
   logic [CntWidth-1:0]   count;
   logic [4:0]            fflags;
   logic                  empty, full, push, pop;
   logic                  bypass_xfer, store, drain;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PtrWidth-1:0] ptr_incr(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_entry = '{result:  in_result_i,
                       status:  in_status_i,
                       ext_bit: in_ext_bit_i,
                       tag:     in_tag_i,
                       aux:     in_aux_i};

   assign empty      = (count == '0);
   assign full       = (count == CntWidth'(Depth));
   assign in_ready_o = ~full;

`ifdef FPNEW_SDOTP_FIFO_BYPASS_EN
   logic bypass_sel;
   assign bypass_sel  = empty & in_valid_i;
   assign head        = bypass_sel ? in_entry : mem[rd_ptr];
   assign out_valid_o = ~empty | in_valid_i;
   assign bypass_xfer = bypass_sel & out_ready_i;
`else
   assign head        = mem[rd_ptr];
   assign out_valid_o = ~empty;
   assign bypass_xfer = 1'b0;
`endif

   assign push  = in_valid_i & in_ready_o;
   assign pop   = out_valid_o & out_ready_i;
   // A bypassed transfer never touches storage; a flush cancels both sides.
   assign store = push & ~bypass_xfer & ~flush_i;
   assign drain = pop & ~bypass_xfer & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         fflags <= '0;
         // NOTE: storage is reset as well because out_* must read 0 after reset.
         for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
      end else begin
         if (store) mem[wr_ptr] <= in_entry;

         if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (store) wr_ptr <= ptr_incr(wr_ptr);
            if (drain) rd_ptr <= ptr_incr(rd_ptr);
            case ({store, drain})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end

         // Clear takes effect before the popped entry's status is merged in.
         if (fflags_clr_i)            fflags <= (pop & ~flush_i) ? head.status : '0;
         else if (pop & ~flush_i)     fflags <= fflags | head.status;
      end
   end

   assign out_result_o  = head.result;
   assign out_status_o  = head.status;
   assign out_ext_bit_o = head.ext_bit;
   assign out_tag_o     = head.tag;
   assign out_aux_o     = head.aux;
   assign fflags_o      = fflags;
   assign usage_o       = count;
   assign busy_o        = ~empty;

endmodule

// File: tb/tb_fpnew_sdotp_result_fifo.sv
// Scoreboard bench: Depth=2 and Depth=3 instances share stimulus, each checked against a queue model.
// Honours FPNEW_SDOTP_FIFO_BYPASS_EN when defined for the build.
module tb_fpnew_sdotp_result_fifo;

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  status;
      logic        ext_bit;
      logic [3:0]  tag;
      logic [7:0]  aux;
   } ent_t;

`ifdef FPNEW_SDOTP_FIFO_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ext_bit, out_ready, fflags_clr;
   logic [63:0] in_result;
   logic [4:0]  in_status;
   logic [3:0]  in_tag;
   logic [7:0]  in_aux;

   logic        in_ready  [2];
   logic [63:0] out_result[2];
   logic [4:0]  out_status[2];
   logic        out_ext   [2];
   logic [3:0]  out_tag   [2];
   logic [7:0]  out_aux   [2];
   logic        out_valid [2];
   logic [4:0]  fflags    [2];
   logic [1:0]  usage     [2];
   logic        busy      [2];

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   bit          mon_en = 1'b0;

   ent_t        mq0[$], mq1[$];
   logic [4:0]  mfl0 = '0, mfl1 = '0;

   always #5 clk = ~clk;

   fpnew_sdotp_result_fifo #(.LaneWidth(64), .Depth(2), .TagType(logic [3:0]), .AuxType(logic [7:0])) u_d2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_result_i(in_result), .in_status_i(in_status), .in_ext_bit_i(in_ext_bit),
      .in_tag_i(in_tag), .in_aux_i(in_aux), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
      .out_result_o(out_result[0]), .out_status_o(out_status[0]), .out_ext_bit_o(out_ext[0]),
      .out_tag_o(out_tag[0]), .out_aux_o(out_aux[0]), .out_valid_o(out_valid[0]),
      .out_ready_i(out_ready), .fflags_o(fflags[0]), .fflags_clr_i(fflags_clr),
      .usage_o(usage[0]), .busy_o(busy[0]));

   fpnew_sdotp_result_fifo #(.LaneWidth(64), .Depth(3), .TagType(logic [3:0]), .AuxType(logic [7:0])) u_d3 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_result_i(in_result), .in_status_i(in_status), .in_ext_bit_i(in_ext_bit),
      .in_tag_i(in_tag), .in_aux_i(in_aux), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
      .out_result_o(out_result[1]), .out_status_o(out_status[1]), .out_ext_bit_o(out_ext[1]),
      .out_tag_o(out_tag[1]), .out_aux_o(out_aux[1]), .out_valid_o(out_valid[1]),
      .out_ready_i(out_ready), .fflags_o(fflags[1]), .fflags_clr_i(fflags_clr),
      .usage_o(usage[1]), .busy_o(busy[1]));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t cur_in();
      return '{result: in_result, status: in_status, ext_bit: in_ext_bit, tag: in_tag, aux: in_aux};
   endfunction

   // Reference model: a bounded queue plus a sticky flag register.
   task automatic model_step(input int dep, inout ent_t q[$], inout logic [4:0] fl);
      bit   valid, pop, push, byp_xfer;
      ent_t head;
      if (rst) begin
         q.delete();
         fl = '0;
      end else if (flush) begin
         q.delete();
         if (fflags_clr) fl = '0;
      end else begin
         valid    = (q.size() != 0) || (Byp && in_valid);
         head     = (q.size() != 0) ? q[0] : cur_in();
         pop      = valid && out_ready;
         push     = in_valid && (q.size() != dep);
         byp_xfer = Byp && (q.size() == 0) && in_valid && out_ready;
         if (fflags_clr) fl = pop ? head.status : 5'd0;
         else if (pop)   fl = fl | head.status;
         if (!byp_xfer) begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(cur_in());
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(2, mq0, mfl0);
      model_step(3, mq1, mfl1);
   end

   task automatic monitor(input string nm, input int dep, input ent_t q[$], input logic [4:0] fl, input int d);
      bit   exp_valid;
      ent_t act;
      exp_valid = (q.size() != 0) || (Byp && in_valid);
      act = '{result: out_result[d], status: out_status[d], ext_bit: out_ext[d], tag: out_tag[d], aux: out_aux[d]};
      check({nm, "_valid"},  128'(out_valid[d]), 128'(exp_valid));
      check({nm, "_ready"},  128'(in_ready[d]),  128'(q.size() != dep));
      check({nm, "_usage"},  128'(usage[d]),     128'(q.size()));
      check({nm, "_busy"},   128'(busy[d]),      128'(q.size() != 0));
      check({nm, "_fflags"}, 128'(fflags[d]),    128'(fl));
      if (exp_valid) check({nm, "_head"}, 128'(act), 128'((q.size() != 0) ? q[0] : cur_in()));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         monitor("d2", 2, mq0, mfl0, 0);
         monitor("d3", 3, mq1, mfl1, 1);
      end
   end

   // Advance to the next cycle, apply inputs, and return at that cycle's falling edge.
   task automatic cyc(input logic v, input logic [63:0] r, input logic [4:0] s, input logic [3:0] t,
                      input logic ordy, input logic fl, input logic clr);
      @(posedge clk);
      #1;
      in_valid   = v;
      in_result  = r;
      in_status  = s;
      in_tag     = t;
      in_ext_bit = logic'($urandom_range(0, 1));
      in_aux     = 8'($urandom);
      out_ready  = ordy;
      flush      = fl;
      fflags_clr = clr;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, 64'd0, 5'd0, 4'd0, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; fflags_clr = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_result = 64'h77; in_status = 5'h1f; in_tag = 4'hf; in_aux = 8'h55; in_ext_bit = 1'b1;
      @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;

      // Nothing captured while reset was held with in_valid high.
      idle(1'b0);
      for (int d = 0; d < 2; d++) begin
         check("rst_out_valid", 128'(out_valid[d]), 128'(0));
         check("rst_in_ready",  128'(in_ready[d]),  128'(1));
         check("rst_usage",     128'(usage[d]),     128'(0));
         check("rst_fflags",    128'(fflags[d]),    128'(0));
      end

      // Fill with no downstream ready.
      cyc(1'b1, 64'hA, 5'h01, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hB, 5'h05, 4'd2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hC, 5'h00, 4'd3, 1'b0, 1'b0, 1'b0);
      check("fill_d2_usage", 128'(usage[0]), 128'(2));
      check("fill_d2_ready", 128'(in_ready[0]), 128'(0));
      idle(1'b0);
      check("fill_d3_usage", 128'(usage[1]), 128'(3));

      // Full with concurrent push and pop: push refused, usage drops.
      cyc(1'b1, 64'hD, 5'h00, 4'd4, 1'b1, 1'b0, 1'b0);
      check("full_d3_ready", 128'(in_ready[1]), 128'(0));
      idle(1'b1);
      check("fullpop_d3_usage", 128'(usage[1]), 128'(2));
      check("fullpop_d2_usage", 128'(usage[0]), 128'(1));
      repeat (3) idle(1'b1);
      idle(1'b0);
      check("flags_d2", 128'(fflags[0]), 128'(5'h05));
      check("flags_d3", 128'(fflags[1]), 128'(5'h05));

      // Pop together with clear: only the popped status survives.
      cyc(1'b1, 64'hE, 5'h10, 4'd5, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 64'h0, 5'h00, 4'd0, 1'b1, 1'b0, 1'b1);
      idle(1'b0);
      check("clrpop_d2", 128'(fflags[0]), 128'(5'h10));
      check("clrpop_d3", 128'(fflags[1]), 128'(5'h10));

      // Flush with two entries and a concurrent push.
      cyc(1'b1, 64'hF1, 5'h02, 4'd6, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hF2, 5'h04, 4'd7, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hEE, 5'h08, 4'd8, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      check("flush_usage", 128'(usage[1]), 128'(0));
      check("flush_fflags", 128'(fflags[1]), 128'(5'h10));
      idle(1'b1);
      check("flush_no_ghost", 128'(out_valid[0]), 128'(0));

      // Push into an empty FIFO with downstream ready.
      cyc(1'b1, 64'h3C00, 5'h00, 4'd9, 1'b1, 1'b0, 1'b0);
`ifdef FPNEW_SDOTP_FIFO_BYPASS_EN
      check("byp_result", 128'(out_result[0]), 128'(64'h3C00));
      check("byp_valid",  128'(out_valid[0]),  128'(1));
      idle(1'b1);
      check("byp_usage",  128'(usage[0]),      128'(0));
`else
      check("lat_valid0", 128'(out_valid[0]), 128'(0));
      idle(1'b1);
      check("lat_valid1", 128'(out_valid[0]), 128'(1));
      check("lat_result", 128'(out_result[0]), 128'(64'h3C00));
`endif
      idle(1'b1);

      // Randomized traffic with occasional clears and flushes.
      for (int i = 0; i < 400; i++) begin
         cyc(logic'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             4'($urandom), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 15) == 0));
      end
      repeat (5) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
